rom_index_sequencer: RTL and testbench

- Upstream driver and output stage for the 5-bit-in / 6-bit-out combinational lookup ROM.
- On a start request it walks the ROM address from FIRST_IDX to LAST_IDX inclusive, one address per accepted beat.
- It registers each ROM word into a one-entry valid/ready output stage tagged with its index, and pulses done after the last word is accepted.

---
 rtl/rom_index_sequencer.sv | 88 ++++++++
 tb/tb_rom_index_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_index_sequencer.sv
// rom_index_sequencer: sweeps a combinational ROM from FIRST_IDX to LAST_IDX and
// presents each word, tagged with its address, through a one-entry valid/ready register.
module rom_index_sequencer #(
  parameter int IDX_W     = 5,
  parameter int DATA_W    = 6,
  parameter int FIRST_IDX = 1,
  parameter int LAST_IDX  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IDX_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  localparam logic [IDX_W-1:0] LP_FIRST = IDX_W'(FIRST_IDX);
  localparam logic [IDX_W-1:0] LP_LAST  = IDX_W'(LAST_IDX);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_out_data;
  logic [IDX_W-1:0]    r_out_index;
  logic                r_out_valid;
  logic                w_load, w_accept, w_last;

  // The output register refills in the same cycle it is drained, so a held-high
  // ready gives one beat per clock.
  assign w_accept = r_out_valid && out_ready;
  assign w_load   = (r_state == S_RUN) && (!r_out_valid || out_ready);
  // Compared before increment: LAST_IDX may be the all-ones address.
  assign w_last   = (r_idx == LP_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_load && w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_accept) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= LP_FIRST;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= rom_data;
      r_out_index <= r_idx;
      r_out_valid <= 1'b1;
      r_idx       <= w_last ? LP_FIRST : r_idx + IDX_W'(1);
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end
  end

  assign rom_addr  = r_idx;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rom_index_sequencer.sv
// Bench for rom_index_sequencer: timeline table, directed corner sequences, and
// randomized ready/start/reset checked by a transaction-level scoreboard.
module tb_rom_index_sequencer;
  localparam int FIRST = 1;
  localparam int LAST  = 24;

  logic       clk = 1'b0;
  logic       rst, start, out_ready, start2;
  logic [4:0] rom_addr, out_index, rom_addr2, out_index2;
  logic [5:0] rom_data, out_data, rom_data2, out_data2;
  logic       out_valid, busy, done, out_valid2, busy2, done2;
  logic       ready2 = 1'b1;

  logic [5:0] rom_tbl [32];
  logic [5:0] exp_seq [24] = '{6'h00, 6'h01, 6'h02, 6'h06, 6'h07, 6'h0C,
                               6'h10, 6'h11, 6'h12, 6'h16, 6'h17, 6'h1C,
                               6'h20, 6'h21, 6'h22, 6'h26, 6'h27, 6'h2C,
                               6'h30, 6'h31, 6'h32, 6'h36, 6'h37, 6'h3C};

  assign rom_data  = rom_tbl[rom_addr];
  assign rom_data2 = rom_tbl[rom_addr2];

  always #5 clk = ~clk;

  rom_index_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done));

  rom_index_sequencer #(.IDX_W(5), .DATA_W(6), .FIRST_IDX(7), .LAST_IDX(12)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .out_data(out_data2), .out_index(out_index2), .out_valid(out_valid2),
    .out_ready(ready2), .busy(busy2), .done(done2));

  int n_chk = 0;
  int n_err = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick(input logic st, input logic rd, input logic rs, input logic st2);
    @(posedge clk); #1;
    start = st; out_ready = rd; rst = rs; start2 = st2;
    @(negedge clk);
  endtask

  // Scoreboard: a sweep is an ordered list of indices FIRST..LAST that must each be
  // accepted exactly once, with done one cycle after the last accept.
  initial begin
    logic m_idle = 1'b1, m_sw = 1'b0, m_done = 1'b0, acc_last;
    int   m_age = 0, m_next = FIRST;
    logic p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b1;
    logic [4:0] p_index = '0;
    logic [5:0] p_data = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("mon_done", done, m_done);
        chk("mon_busy", busy, m_sw);
        if (m_idle) chk("mon_idle_addr", rom_addr, FIRST);
        if (!m_sw) chk("mon_valid_outside_sweep", out_valid, 1'b0);
        if (p_valid && !p_ready && !p_rst) begin
          chk("mon_hold_valid", out_valid, 1'b1);
          chk("mon_hold_index", out_index, p_index);
          chk("mon_hold_data", out_data, p_data);
        end
        if (m_sw && m_age >= 1 && m_next <= LAST) chk("mon_no_bubble", out_valid, 1'b1);
        acc_last = 1'b0;
        if (m_sw && out_valid && out_ready) begin
          chk("mon_beat_index", out_index, m_next);
          chk("mon_beat_data", out_data, rom_tbl[m_next]);
          if (m_next == LAST) acc_last = 1'b1;
          m_next++;
        end
        if (rst) begin
          m_idle = 1'b1; m_sw = 1'b0; m_done = 1'b0; m_next = FIRST;
        end else if (m_idle) begin
          if (start) begin m_idle = 1'b0; m_sw = 1'b1; m_age = 0; m_next = FIRST; end
        end else if (m_sw) begin
          m_age++;
          if (acc_last) begin m_sw = 1'b0; m_done = 1'b1; end
        end else if (m_done) begin
          m_done = 1'b0; m_idle = 1'b1;
        end
        p_valid = out_valid; p_ready = out_ready; p_rst = rst;
        p_index = out_index; p_data = out_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       start;
    logic       ready;
    logic       exp_valid;
    logic [4:0] exp_index;
    logic [5:0] exp_data;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vt [28];

  initial begin
    int beats, dones, rc;
    logic seen_done, aborted;

    for (int i = 0; i < 32; i++) rom_tbl[i] = 6'(i * 5 + 3) ^ 6'h2A;
    for (int i = 0; i < 24; i++) rom_tbl[i + 1] = exp_seq[i];

    // Default-sweep timeline: start in cycle 0, beats in 2..25, done in 26.
    for (int c = 0; c < 28; c++) begin
      vt[c].start     = (c == 0);
      vt[c].ready     = 1'b1;
      vt[c].exp_valid = (c >= 2 && c <= 25);
      vt[c].exp_index = (c >= 2 && c <= 25) ? 5'(c - 1) : 5'd0;
      vt[c].exp_data  = (c >= 2 && c <= 25) ? exp_seq[c - 2] : 6'd0;
      vt[c].exp_busy  = (c >= 1 && c <= 25);
      vt[c].exp_done  = (c == 26);
    end

    rst = 1'b1; start = 1'b0; out_ready = 1'b0; start2 = 1'b0;
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    mon_en = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_data", out_data, 6'd0);
    chk("reset_index", out_index, 5'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_addr", rom_addr, 5'd1);
    chk("reset_addr2", rom_addr2, 5'd7);
    tick(1'b0, 1'b1, 1'b0, 1'b0);

    // Table-driven full sweep
    for (int c = 0; c < 28; c++) begin
      tick(vt[c].start, vt[c].ready, 1'b0, 1'b0);
      chk($sformatf("tbl_valid_c%0d", c), out_valid, vt[c].exp_valid);
      chk($sformatf("tbl_busy_c%0d", c), busy, vt[c].exp_busy);
      chk($sformatf("tbl_done_c%0d", c), done, vt[c].exp_done);
      if (vt[c].exp_valid) begin
        chk($sformatf("tbl_index_c%0d", c), out_index, vt[c].exp_index);
        chk($sformatf("tbl_data_c%0d", c), out_data, vt[c].exp_data);
      end
    end

    // Backpressure in cycles 5..8 freezes index 4
    for (int c = 0; c < 32; c++) begin
      tick(c == 0, !(c >= 5 && c <= 8), 1'b0, 1'b0);
      if (c >= 5 && c <= 9) begin
        chk($sformatf("bp_hold_index_c%0d", c), out_index, 5'd4);
        chk($sformatf("bp_hold_data_c%0d", c), out_data, 6'h06);
      end
      if (c == 10) begin
        chk("bp_next_index", out_index, 5'd5);
        chk("bp_next_data", out_data, 6'h07);
      end
      chk($sformatf("bp_done_c%0d", c), done, c == 30);
    end

    // Final beat stalled for 3 cycles
    for (int c = 0; c < 31; c++) begin
      tick(c == 0, !(c >= 25 && c <= 27), 1'b0, 1'b0);
      if (c >= 25 && c <= 28) begin
        chk($sformatf("fs_busy_c%0d", c), busy, 1'b1);
        chk($sformatf("fs_index_c%0d", c), out_index, 5'd24);
        chk($sformatf("fs_data_c%0d", c), out_data, 6'h3C);
      end
      chk($sformatf("fs_done_c%0d", c), done, c == 29);
    end

    // start during RUN and DONE is ignored; start in the next IDLE relaunches
    beats = 0; dones = 0;
    for (int c = 0; c < 55; c++) begin
      tick(c == 0 || c == 5 || c == 26 || c == 27, 1'b1, 1'b0, 1'b0);
      if (c <= 27 && out_valid && out_ready) beats++;
      if (c <= 27 && done) dones++;
      if (c == 29) begin
        chk("rs_relaunch_valid", out_valid, 1'b1);
        chk("rs_relaunch_index", out_index, 5'd1);
      end
      if (c == 53) chk("rs_second_done", done, 1'b1);
    end
    chk("rs_first_sweep_beats", beats, 24);
    chk("rs_first_sweep_dones", dones, 1);

    // Reset together with start in cycle 10 aborts the sweep
    beats = 0;
    for (int c = 0; c < 40; c++) begin
      tick(c == 0 || c == 10 || c == 12, 1'b1, c == 10, 1'b0);
      if (c == 11) begin
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", rom_addr, 5'd1);
        chk("rst_done", done, 1'b0);
      end
      if (c >= 11) chk($sformatf("rst_done_c%0d", c), done, c == 38);
      if (c >= 12 && out_valid && out_ready) beats++;
    end
    chk("rst_resweep_beats", beats, 24);

    // Overridden range 7..12 on the second instance
    for (int c = 0; c < 10; c++) begin
      tick(1'b0, 1'b1, 1'b0, c == 0);
      chk($sformatf("ovr_valid_c%0d", c), out_valid2, c >= 2 && c <= 7);
      chk($sformatf("ovr_done_c%0d", c), done2, c == 8);
      if (c >= 2 && c <= 7) begin
        chk($sformatf("ovr_index_c%0d", c), out_index2, 5'(c + 5));
        chk($sformatf("ovr_data_c%0d", c), out_data2, exp_seq[c + 4]);
      end
    end

    // Randomized ready/start, one sweep aborted by reset
    for (int s = 0; s < 6; s++) begin
      seen_done = 1'b0; aborted = 1'b0;
      rc = $urandom_range(3, 25);
      tick(1'b1, $urandom_range(0, 9) < 7, 1'b0, 1'b0);
      for (int c = 1; c < 200 && !seen_done && !aborted; c++) begin
        tick($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, s == 3 && c == rc, 1'b0);
        if (done) seen_done = 1'b1;
        if (s == 3 && c == rc) aborted = 1'b1;
      end
      if (!aborted) chk($sformatf("rand_sweep%0d_done", s), seen_done, 1'b1);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
